// File: rtl/div_sequencer_if.sv
// Request/response bundle between the execute-stage control path and the divider.
// Latency: none (wires only).
// Backpressure: the divider raises oBusy to stall the requester; there is no ready signal.
interface div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             iStart;
  logic [1:0]       iOp;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             iFlush;
  logic             oBusy;
  logic             oDone;
  logic [WIDTH-1:0] oResult;

  // Pipeline control side: issues requests and consumes results.
  modport master (
    output iStart, iOp, iA, iB, iFlush,
    input  oBusy, oDone, oResult
  );

  // Divider side.
  modport slave (
    input  iStart, iOp, iA, iB, iFlush,
    output oBusy, oDone, oResult
  );
endinterface

// File: rtl/div_sequencer.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU (one quotient bit per cycle).
// Latency: WIDTH+2 edges to oDone for normal ops, 1 edge for divide-by-zero and signed overflow.
// Backpressure: oBusy is high in CALC/FIX; iStart is ignored while busy and is not queued.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input logic          iCLK,
  input logic          iRST_n,
  div_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [1:0]       op_q, op_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             accept;
  logic             in_signed;
  logic             in_a_neg;
  logic             in_b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             sgn_ovf;
  logic [WIDTH:0]   rem_sh;
  logic             trial_ok;
  logic [WIDTH-1:0] trial;
  logic             op_signed;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Operand decode and one restoring step; the compare runs on WIDTH+1 bits so nothing wraps.
  always_comb begin
    accept    = ((state_q == IDLE) || (state_q == DONE)) && bus.iStart && !bus.iFlush;
    in_signed = ~bus.iOp[0];
    in_a_neg  = in_signed & bus.iA[WIDTH-1];
    in_b_neg  = in_signed & bus.iB[WIDTH-1];
    // Negating 0x80..0 yields 0x80..0, which read unsigned is exactly the magnitude wanted.
    a_mag     = in_a_neg ? (~bus.iA + 1'b1) : bus.iA;
    b_mag     = in_b_neg ? (~bus.iB + 1'b1) : bus.iB;
    div_zero  = (bus.iB == '0);
    sgn_ovf   = in_signed && (bus.iA == MIN_NEG) && (bus.iB == '1);

    rem_sh    = {rem_q, quot_q[WIDTH-1]};
    trial_ok  = (rem_sh >= {1'b0, dvsr_q});
    // When trial_ok holds the difference is below the divisor, so the low WIDTH bits are exact.
    trial     = rem_sh[WIDTH-1:0] - dvsr_q;

    op_signed = ~op_q[0];
    q_fix     = (op_signed && (a_neg_q ^ b_neg_q)) ? (~quot_q + 1'b1) : quot_q;
    r_fix     = (op_signed && a_neg_q) ? (~rem_q + 1'b1) : rem_q;
  end

  // Next-state logic: flush wins over everything, then accept/iterate/fix-up.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvsr_d   = dvsr_q;
    op_d     = op_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    result_d = result_q;

    if (bus.iFlush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (accept) begin
            op_d    = bus.iOp;
            a_neg_d = in_a_neg;
            b_neg_d = in_b_neg;
            if (div_zero) begin
              result_d = bus.iOp[1] ? bus.iA : '1;
              state_d  = DONE;
            end else if (sgn_ovf) begin
              result_d = bus.iOp[1] ? '0 : MIN_NEG;
              state_d  = DONE;
            end else begin
              rem_d   = '0;
              quot_d  = a_mag;
              dvsr_d  = b_mag;
              cnt_d   = CW'(WIDTH - 1);
              state_d = CALC;
            end
          end
        end
        CALC: begin
          rem_d  = trial_ok ? trial : rem_sh[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], trial_ok};
          if (cnt_q == '0) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin  // FIX
          result_d = op_q[1] ? r_fix : q_fix;
          state_d  = DONE;
        end
      endcase
    end
  end

  // State registers; async reset discards any operation in flight.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvsr_q   <= '0;
      op_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvsr_q   <= dvsr_d;
      op_q     <= op_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      result_q <= result_d;
    end
  end

  assign bus.oBusy   = (state_q == CALC) || (state_q == FIX);
  assign bus.oDone   = (state_q == DONE);
  assign bus.oResult = result_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer: signed/unsigned results, latency,
// special cases, flush, back-to-back issue and asynchronous reset.
module tb_div_sequencer;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  div_sequencer_if #(.WIDTH(32)) bus ();

  div_sequencer #(.WIDTH(32)) dut (
    .iCLK   (clk),
    .iRST_n (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request, then sample each negedge until oDone (bounded at 100 cycles).
  // cycles = number of edges after the accept edge at which oDone is seen (1 = next edge).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int cycles, output int busy_cnt);
    @(negedge clk);
    bus.iStart = 1'b1;
    bus.iOp    = op;
    bus.iA     = a;
    bus.iB     = b;
    @(posedge clk);
    cycles   = 0;
    busy_cnt = 0;
    res      = 32'hDEAD_BEEF;
    while (cycles < 100) begin
      @(negedge clk);
      bus.iStart = 1'b0;
      cycles++;
      if (bus.oBusy) busy_cnt++;
      if (bus.oDone) begin
        res = bus.oResult;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.iStart = 1'b0;
    bus.iOp    = 2'b00;
    bus.iA     = '0;
    bus.iB     = '0;
    bus.iFlush = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.oBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.oBusy); end
    n_cmp++; if (bus.oDone !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.oDone); end
    n_cmp++; if (bus.oResult !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", bus.oResult); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_signed();
    logic [31:0] r;
    int cyc, bsy;
    run_op(OP_DIV, 32'hFFFF_FFEC, 32'd3, r, cyc, bsy);
    n_cmp++; if (r !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL div_m20_3 got=%h exp=fffffffa", r); end
    n_cmp++; if (cyc !== 34) begin n_fail++; $display("FAIL div_latency got=%0d exp=34", cyc); end
    n_cmp++; if (bsy !== 33) begin n_fail++; $display("FAIL div_busy_cycles got=%0d exp=33", bsy); end
    @(negedge clk);
    n_cmp++; if (bus.oDone !== 1'b0) begin n_fail++; $display("FAIL done_one_pulse got=%b exp=0", bus.oDone); end
    n_cmp++; if (bus.oResult !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL result_held_idle got=%h exp=fffffffa", bus.oResult); end
    run_op(OP_REM, 32'hFFFF_FFEC, 32'd3, r, cyc, bsy);
    n_cmp++; if (r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL rem_m20_3 got=%h exp=fffffffe", r); end
    n_cmp++; if (cyc !== 34) begin n_fail++; $display("FAIL rem_latency got=%0d exp=34", cyc); end
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, r, cyc, bsy);
    n_cmp++; if (r !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_7_m2 got=%h exp=fffffffd", r); end
    run_op(OP_REM, 32'd7, 32'hFFFF_FFFE, r, cyc, bsy);
    n_cmp++; if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL rem_7_m2 got=%h exp=00000001", r); end
    run_op(OP_DIV, 32'h8000_0000, 32'd2, r, cyc, bsy);
    n_cmp++; if (r !== 32'hC000_0000) begin n_fail++; $display("FAIL div_min_2 got=%h exp=c0000000", r); end
  endtask

  task automatic test_div_zero();
    logic [31:0] r;
    int cyc, bsy;
    run_op(OP_DIV, 32'h0000_1234, 32'd0, r, cyc, bsy);
    n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_quot got=%h exp=ffffffff", r); end
    n_cmp++; if (cyc !== 1) begin n_fail++; $display("FAIL div0_latency got=%0d exp=1", cyc); end
    n_cmp++; if (bsy !== 0) begin n_fail++; $display("FAIL div0_busy got=%0d exp=0", bsy); end
    run_op(OP_REM, 32'h0000_1234, 32'd0, r, cyc, bsy);
    n_cmp++; if (r !== 32'h0000_1234) begin n_fail++; $display("FAIL rem0 got=%h exp=00001234", r); end
    run_op(OP_DIVU, 32'd5, 32'd0, r, cyc, bsy);
    n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu0 got=%h exp=ffffffff", r); end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    int cyc, bsy;
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, cyc, bsy);
    n_cmp++; if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_div got=%h exp=80000000", r); end
    n_cmp++; if (cyc !== 1) begin n_fail++; $display("FAIL ovf_latency got=%0d exp=1", cyc); end
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, r, cyc, bsy);
    n_cmp++; if (r !== 32'h0000_0000) begin n_fail++; $display("FAIL ovf_rem got=%h exp=00000000", r); end
  endtask

  task automatic test_unsigned();
    logic [31:0] r;
    int cyc, bsy;
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd2, r, cyc, bsy);
    n_cmp++; if (r !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL divu got=%h exp=7fffffff", r); end
    n_cmp++; if (cyc !== 34) begin n_fail++; $display("FAIL divu_latency got=%0d exp=34", cyc); end
    run_op(OP_REMU, 32'hFFFF_FFFF, 32'd2, r, cyc, bsy);
    n_cmp++; if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL remu got=%h exp=00000001", r); end
    n_cmp++; if (cyc !== 34) begin n_fail++; $display("FAIL remu_latency got=%0d exp=34", cyc); end
  endtask

  // Runs right after test_unsigned, so the held result is 1 from REMU.
  task automatic test_flush();
    logic [31:0] r;
    int cyc, bsy, done_seen;
    @(negedge clk);
    bus.iStart = 1'b1; bus.iOp = OP_DIVU; bus.iA = 32'd50; bus.iB = 32'd5;
    @(posedge clk);
    @(negedge clk);
    bus.iStart = 1'b0;
    repeat (9) @(negedge clk);
    bus.iFlush = 1'b1; bus.iStart = 1'b1; bus.iOp = OP_DIVU; bus.iA = 32'd8; bus.iB = 32'd2;
    @(negedge clk);
    bus.iFlush = 1'b0; bus.iStart = 1'b0;
    n_cmp++; if (bus.oBusy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%b exp=0", bus.oBusy); end
    n_cmp++; if (bus.oResult !== 32'h0000_0001) begin n_fail++; $display("FAIL flush_result_held got=%h exp=00000001", bus.oResult); end
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.oDone) done_seen++;
    end
    n_cmp++; if (done_seen !== 0) begin n_fail++; $display("FAIL flush_no_done got=%0d exp=0", done_seen); end
    run_op(OP_DIVU, 32'd100, 32'd7, r, cyc, bsy);
    n_cmp++; if (r !== 32'd14) begin n_fail++; $display("FAIL after_flush got=%h exp=0000000e", r); end
    n_cmp++; if (cyc !== 34) begin n_fail++; $display("FAIL after_flush_latency got=%0d exp=34", cyc); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [31:0] r;
    logic got;
    @(negedge clk);
    bus.iStart = 1'b1; bus.iOp = OP_DIVU; bus.iA = 32'd9; bus.iB = 32'd4;
    @(posedge clk);
    cyc = 0; got = 1'b0; r = 32'hDEAD_BEEF;
    while (cyc < 100 && !got) begin
      @(negedge clk);
      cyc++;
      if (bus.oDone) begin got = 1'b1; r = bus.oResult; end
    end
    n_cmp++; if (r !== 32'd2) begin n_fail++; $display("FAIL b2b_first got=%h exp=00000002", r); end
    n_cmp++; if (cyc !== 34) begin n_fail++; $display("FAIL b2b_first_latency got=%0d exp=34", cyc); end
    bus.iOp = OP_REMU;
    @(posedge clk);
    cyc = 0; got = 1'b0; r = 32'hDEAD_BEEF;
    while (cyc < 100 && !got) begin
      @(negedge clk);
      bus.iStart = 1'b0;
      cyc++;
      if (bus.oDone) begin got = 1'b1; r = bus.oResult; end
    end
    n_cmp++; if (r !== 32'd1) begin n_fail++; $display("FAIL b2b_second got=%h exp=00000001", r); end
    n_cmp++; if (cyc !== 34) begin n_fail++; $display("FAIL b2b_second_latency got=%0d exp=34", cyc); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int cyc, bsy, done_seen;
    @(negedge clk);
    bus.iStart = 1'b1; bus.iOp = OP_DIVU; bus.iA = 32'd1000; bus.iB = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.iStart = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.oBusy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=0", bus.oBusy); end
    n_cmp++; if (bus.oDone !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got=%b exp=0", bus.oDone); end
    n_cmp++; if (bus.oResult !== 32'h0) begin n_fail++; $display("FAIL rst_mid_result got=%h exp=0", bus.oResult); end
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.oDone) done_seen++;
    end
    n_cmp++; if (done_seen !== 0) begin n_fail++; $display("FAIL rst_mid_no_done got=%0d exp=0", done_seen); end
    run_op(OP_DIVU, 32'd1000, 32'd3, r, cyc, bsy);
    n_cmp++; if (r !== 32'd333) begin n_fail++; $display("FAIL after_reset got=%h exp=0000014d", r); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_signed();
    test_div_zero();
    test_overflow();
    test_unsigned();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle iterative divider and controller for the RV32M division operations DIV, DIVU, REM and REMU.
- Takes those operations off the single-cycle ALU path. The control path issues a start pulse and holds the pipeline while the busy output is high.
- Sits beside the ALU in the execute stage. Its result is muxed onto the ALU result path when done is high.

Parameters:
- WIDTH, 32, operand and result width. The iteration counter is clog2(WIDTH) bits wide.

Ports:
- iCLK  in  1  system clock; all state updates on the rising edge.
- iRST_n  in  1  asynchronous, active-low reset.
- iStart  in  1  request a new division; sampled only when the request is acceptable (see Behaviour).
- iOp  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- iA  in  WIDTH  dividend, captured on accept.
- iB  in  WIDTH  divisor, captured on accept.
- iFlush  in  1  synchronous abort (pipeline flush).
- oBusy  out  1  high while the operation is in progress; stall request to the pipeline.
- oDone  out  1  one-cycle pulse: oResult is valid.
- oResult  out  WIDTH  quotient or remainder; held stable until the next accept.

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Reset (async, iRST_n=0): state IDLE, oBusy=0, oDone=0, oResult=0, counter=0, internal registers 0. A reset mid-operation discards the operation with no oDone.
- Accept: iStart=1 while state is IDLE or DONE, with iFlush=0. The accept edge captures iOp, iA and iB. iStart in CALC or FIX is ignored (not queued).
- Special cases are resolved at the accept edge, which goes directly to DONE (oDone one cycle after accept):
  - Divisor zero: quotient = all ones; remainder = iA.
  - Signed overflow (DIV/REM with iA=0x80000000, iB=0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- Normal path:
  - Accept edge loads the magnitudes. Signed ops use |iA| and |iB|; unsigned ops use raw values.
  - Load partial remainder = 0, counter = WIDTH-1, state CALC.
  - CALC performs one restoring step per cycle: shift {rem,quot} left 1; trial = rem - divisor; if trial is non-negative, rem = trial and quotient LSB = 1.
  - After WIDTH CALC cycles (counter reaches 0), go to FIX.
  - FIX applies signs. The quotient is negated iff the op is signed and the operand signs differ. The remainder is negated iff the op is signed and the dividend is negative. FIX then selects quotient (DIV/DIVU) or remainder (REM/REMU) into oResult and goes to DONE.
- DONE lasts one cycle, with oDone=1. Next edge: back to IDLE, or a new accept if iStart=1.
- Latency: normal ops raise oDone WIDTH+2 edges after the accept edge (34 for WIDTH=32); special cases raise it 1 edge after.
- oBusy = 1 in CALC and FIX only. oBusy is low in IDLE and DONE, so back-to-back issue needs no bubble.
- oResult changes only on the FIX edge or on a special-case accept edge. It is otherwise held, including through IDLE and a flush.
- iFlush=1 at any edge: next state IDLE, oDone=0, oBusy=0, counter cleared, oResult unchanged. iFlush has priority over iStart in the same cycle. iFlush in IDLE has no effect.
- oDone is never asserted for a flushed or reset operation. At most one oDone is asserted per accept.
- Arithmetic uses WIDTH+1-bit trial subtraction, with no overflow or wrap. Magnitude of 0x80000000 is taken as the unsigned value 0x80000000.

Test Plan:
- DIV iA=-20 (0xFFFFFFEC), iB=3 -> oBusy high for 33 cycles, oDone on edge 34 after accept, oResult=0xFFFFFFFA (-6). Repeat as REM -> 0xFFFFFFFE (-2).
- DIVU iA=0xFFFFFFFF, iB=2 -> 0x7FFFFFFF; REMU same operands -> 0x00000001; each takes 34 cycles.
- Divide by zero: DIV iA=0x1234, iB=0 -> oDone 1 cycle after accept, oResult=0xFFFFFFFF, oBusy never high. REM iA=0x1234, iB=0 -> 0x00001234.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 with 1-cycle latency. REM of the same operands -> 0.
- Flush mid-CALC (cycle 10) with iStart also high -> state IDLE, no oDone, oResult keeps its prior value. A fresh DIVU 100/7 afterwards -> 14, with correct latency.
- Back-to-back: iStart held high through the DONE cycle with DIVU 9/4 -> first result 2 pulses oDone; the second op (REMU 9/4) is accepted on that edge and returns 1 after 34 more cycles. Also assert reset mid-CALC -> all outputs 0 immediately, no oDone.
